debug_trace_unit: RTL and testbench
===================================

Name: debug_trace_unit

Overview:
- Parametrised debug/trace block that sits beside the RISC-V datapath at the top level.
- Replaces the fixed set of per-cycle probe outputs with three functions:
  - records retired instructions into a circular trace buffer;
  - gates core advance through a run/halt/single-step state machine;
  - halts on programmable PC breakpoints.
- A host (board switches, or a bench) reads the trace back through a valid/ready pop port.

Parameters:
- XLEN, 32, datapath word width (PC, instruction, write-back data).
- DEPTH, 16, trace entries; power of two, at least 2.
- NUM_BREAK, 2, number of PC breakpoint comparators, 1 to 8.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- iValid  in  1  datapath retired an instruction this cycle; sampled only when oCoreEn=1.
- iPC  in  XLEN  PC of the retiring instruction.
- iInstruction  in  32  retiring instruction word.
- iRegWrite  in  1  retiring instruction writes rd.
- iRd  in  5  destination register.
- iWriteData  in  XLEN  write-back value.
- iHaltReq  in  1  level; request halt.
- iRunReq  in  1  pulse; resume free-running.
- iStepReq  in  1  pulse; execute exactly one instruction.
- iBreakEn  in  NUM_BREAK  per-comparator enable.
- iBreakAddr  in  NUM_BREAK*XLEN  packed breakpoint addresses; comparator k uses slice k.
- iPopReady  in  1  host accepts the head entry.
- oCoreEn  out  1  datapath clock-enable (PC and register-file update).
- oState  out  2  0=RUN, 1=HALTED, 2=STEP.
- oBreakHit  out  NUM_BREAK  sticky per-comparator hit flags.
- oPopValid  out  1  head entry available.
- oPopPC  out  XLEN  head entry PC.
- oPopInstr  out  32  head entry instruction.
- oPopRd  out  6  {regwrite, rd} of head entry.
- oPopData  out  XLEN  head entry write-back data.
- oCount  out  $clog2(DEPTH)+1  entries held.
- oOverflow  out  1  sticky; an entry was overwritten.

Behaviour:
- Reset:
  - state=HALTED, oCoreEn=0, buffer empty, oCount=0, oOverflow=0, oBreakHit=0.
  - All pop outputs 0.
  - Reset mid-operation discards the buffer contents.
- oCoreEn is combinational from state: 1 in RUN and STEP, 0 in HALTED.
- Retire event: iValid & oCoreEn.
- Breakpoint match: retire event with iBreakEn[k] & (iPC == slice k) for any k.
- State transitions (registered, take effect next cycle):
  - RUN -> HALTED on iHaltReq or a breakpoint match.
  - HALTED -> RUN on iRunReq & !iHaltReq.
  - HALTED -> STEP on iStepReq; iRunReq wins if both arrive together.
  - STEP -> HALTED on the first retire event.
  - STEP -> HALTED on iHaltReq even without a retire.
- Breakpoint behaviour:
  - The matching instruction itself retires and is traced.
  - The halt is seen from the next cycle.
  - The matching oBreakHit[k] bit sets.
  - iRunReq clears all oBreakHit bits.
- Push:
  - Every retire event writes {PC, instr, regwrite, rd, data} at the write pointer; the pointer advances modulo DEPTH.
  - Buffer full and no pop in the same cycle: overwrite the oldest entry, advance the read pointer, set oOverflow, keep oCount=DEPTH.
- Pop:
  - oPopValid = (oCount != 0).
  - Pop outputs are a combinational read of the head entry.
  - oPopValid & iPopReady advances the read pointer.
- Simultaneous push and pop:
  - Both pointers advance and oCount is unchanged.
  - Full + push + pop: no overflow.
  - Empty + push + pop: the pop is ignored because oPopValid was 0.
- oOverflow clears only on reset or on a pop that empties the buffer.
- Latency: a retired entry is visible at the pop port the cycle after retire.

Optional Feature:
- TRACE_WDATA_EN defined: the buffer stores iWriteData, and oPopData returns it.
- TRACE_WDATA_EN undefined:
  - No storage for data; entry width shrinks by XLEN.
  - oPopData is tied to 0.
  - Every other behaviour is identical.

Decomposition:
- Shared package/params file holds:
  - state encodings ST_RUN=0, ST_HALTED=1, ST_STEP=2;
  - the trace entry field layout (offsets and widths);
  - the DEPTH power-of-two check.
- One natural sub-module: trace_ring_buffer, a parametrised width/depth circular buffer with overwrite-on-full, count and overflow.
- debug_trace_unit keeps the FSM and comparators.

Test Plan:
- Reset, then iRunReq pulse, then retire PC=0x00,0x04,0x08 -> oCoreEn=1 from the cycle after iRunReq; oCount=3; pops return PCs 0x00,0x04,0x08 in order; oPopValid=0 afterwards.
- iBreakEn=01, iBreakAddr[0]=0x10, run through 0x0C,0x10,0x14 -> 0x10 traced; state=HALTED next cycle; oBreakHit=01; 0x14 not traced.
- HALTED, iStepReq pulse -> exactly one entry pushed; oCoreEn is 1 for the STEP cycles only, then state returns to 1.
- DEPTH=16, 18 retires with no pops -> oCount=16, oOverflow=1; first pop returns retire #3 (overwrite of #1 and #2).
- Full buffer, simultaneous retire and pop every cycle for 5 cycles -> oCount stays 16, oOverflow not newly set, pops are in order.
- Assert reset mid-run with oCount=5 -> immediately oCount=0, state=HALTED, oCoreEn=0, oPopValid=0.

Source files
------------

// File: rtl/debug_trace_unit_pkg.sv
// -----------------------------------------------------------------------------
// debug_trace_unit_pkg
// Shared definitions for the debug/trace unit:
//   - run-control state encodings
//   - trace entry field layout (LSB offsets and widths as functions of XLEN)
//   - DEPTH legality check
// Optional feature macro: TRACE_WDATA_EN (adds the write-back data field).
// -----------------------------------------------------------------------------
package debug_trace_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } dbg_state_e;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RD_W    = 6;   // {regwrite, rd}

    // Entry layout, LSB first: PC | instruction | {regwrite, rd} | [data]
    function automatic int unsigned ent_pc_lsb(input int unsigned xlen);
        return 0 * xlen;
    endfunction

    function automatic int unsigned ent_instr_lsb(input int unsigned xlen);
        return xlen;
    endfunction

    function automatic int unsigned ent_rd_lsb(input int unsigned xlen);
        return xlen + INSTR_W;
    endfunction

    function automatic int unsigned ent_data_lsb(input int unsigned xlen);
        return xlen + INSTR_W + RD_W;
    endfunction

    function automatic int unsigned ent_w(input int unsigned xlen);
`ifdef TRACE_WDATA_EN
        return 2 * xlen + INSTR_W + RD_W;
`else
        return xlen + INSTR_W + RD_W;
`endif
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/debug_trace_unit_ring.sv
// -----------------------------------------------------------------------------
// trace_ring_buffer
// Circular buffer of W-bit entries, DEPTH deep (power of two), with
// overwrite-on-full, occupancy count and sticky overflow flag.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   push_i, data_i        write an entry
//   pop_ready_i           host accepts the head entry
//   pop_valid_o, data_o   head entry (data_o is 0 while empty)
//   count_o               entries held
//   overflow_o            sticky; an unread entry was overwritten
// -----------------------------------------------------------------------------
module trace_ring_buffer #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_ready_i,
    output logic                     pop_valid_o,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          pop;

    assign pop_valid_o = (cnt_q != '0);
    assign pop         = pop_valid_o & pop_ready_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push_i) begin
            wr_d = wr_q + PTR_ONE;
        end
        if (push_i && pop) begin
            rd_d = rd_q + PTR_ONE;
        end else if (push_i) begin
            if (cnt_q == CNT_FULL) begin
                // Write pointer has caught the read pointer: drop the oldest.
                rd_d  = rd_q + PTR_ONE;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pop) begin
            rd_d  = rd_q + PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry storage carries no reset; stale contents are masked by count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o     = pop_valid_o ? mem_q[rd_q] : '0;
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/debug_trace_unit.sv
// -----------------------------------------------------------------------------
// debug_trace_unit
// Debug/trace block beside the RISC-V datapath: run/halt/single-step control
// gating the core clock-enable, NUM_BREAK PC breakpoint comparators with
// sticky hit flags, and a DEPTH-entry trace of retired instructions read back
// through a valid/ready pop port.
// Optional feature macro: TRACE_WDATA_EN -- when defined the trace stores the
// write-back data and oPopData returns it; otherwise oPopData is 0.
// Ports:
//   clock, reset                    clock, asynchronous active-high reset
//   iValid/iPC/iInstruction/
//   iRegWrite/iRd/iWriteData        retiring instruction (used when oCoreEn=1)
//   iHaltReq/iRunReq/iStepReq       run control requests
//   iBreakEn/iBreakAddr             breakpoint enables and packed addresses
//   iPopReady                       host accepts head entry
//   oCoreEn, oState, oBreakHit      run control status
//   oPopValid/oPopPC/oPopInstr/
//   oPopRd/oPopData                 head trace entry
//   oCount, oOverflow               trace occupancy and sticky overflow
// -----------------------------------------------------------------------------
module debug_trace_unit
    import debug_trace_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned NUM_BREAK = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iValid,
    input  logic [XLEN-1:0]           iPC,
    input  logic [31:0]               iInstruction,
    input  logic                      iRegWrite,
    input  logic [4:0]                iRd,
    input  logic [XLEN-1:0]           iWriteData,
    input  logic                      iHaltReq,
    input  logic                      iRunReq,
    input  logic                      iStepReq,
    input  logic [NUM_BREAK-1:0]      iBreakEn,
    input  logic [NUM_BREAK*XLEN-1:0] iBreakAddr,
    input  logic                      iPopReady,
    output logic                      oCoreEn,
    output logic [1:0]                oState,
    output logic [NUM_BREAK-1:0]      oBreakHit,
    output logic                      oPopValid,
    output logic [XLEN-1:0]           oPopPC,
    output logic [31:0]               oPopInstr,
    output logic [5:0]                oPopRd,
    output logic [XLEN-1:0]           oPopData,
    output logic [$clog2(DEPTH):0]    oCount,
    output logic                      oOverflow
);
    localparam int unsigned EW = ent_w(XLEN);

    if (!depth_ok(DEPTH) || NUM_BREAK < 1 || NUM_BREAK > 8) begin : g_bad_param
        $error("debug_trace_unit: DEPTH must be a power of two >= 2, NUM_BREAK 1..8");
    end

    dbg_state_e           state_q, state_d;
    logic [NUM_BREAK-1:0] hit_q, hit_d;
    logic [NUM_BREAK-1:0] match;
    logic                 retire;
    logic [EW-1:0]        entry, head;

    assign retire = iValid & oCoreEn;

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_BREAK; k++) begin
            if (retire && iBreakEn[k] && (iPC == iBreakAddr[k*XLEN +: XLEN])) begin
                match[k] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_HALTED;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (iHaltReq || (match != '0)) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (iRunReq && !iHaltReq) state_d = ST_RUN;
                else if (iStepReq)        state_d = ST_STEP;
            end
            ST_STEP: begin
                if (retire || iHaltReq) state_d = ST_HALTED;
            end
            default: state_d = ST_HALTED;
        endcase
        // A run request clears old hits; a hit on the same cycle still sticks.
        hit_d = (iRunReq ? '0 : hit_q) | match;
    end

    // Outputs
    always_comb begin
        oCoreEn = (state_q != ST_HALTED);
        oState  = state_q;
    end

    assign oBreakHit = hit_q;

`ifdef TRACE_WDATA_EN
    assign entry = {iWriteData, iRegWrite, iRd, iInstruction, iPC};
`else
    logic unused_wdata;
    assign unused_wdata = ^iWriteData;
    assign entry = {iRegWrite, iRd, iInstruction, iPC};
`endif

    trace_ring_buffer #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (retire),
        .data_i      (entry),
        .pop_ready_i (iPopReady),
        .pop_valid_o (oPopValid),
        .data_o      (head),
        .count_o     (oCount),
        .overflow_o  (oOverflow)
    );

    assign oPopPC    = head[ent_pc_lsb(XLEN)    +: XLEN];
    assign oPopInstr = head[ent_instr_lsb(XLEN) +: INSTR_W];
    assign oPopRd    = head[ent_rd_lsb(XLEN)    +: RD_W];
`ifdef TRACE_WDATA_EN
    assign oPopData  = head[ent_data_lsb(XLEN)  +: XLEN];
`else
    assign oPopData  = '0;
`endif

endmodule

// File: tb/tb_debug_trace_unit.sv
module tb_debug_trace_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int NB    = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            iValid, iRegWrite, iHaltReq, iRunReq, iStepReq, iPopReady;
    logic [XLEN-1:0] iPC, iWriteData;
    logic [31:0]     iInstruction;
    logic [4:0]      iRd;
    logic [NB-1:0]   iBreakEn;
    logic [NB*XLEN-1:0] iBreakAddr;
    logic            oCoreEn, oPopValid, oOverflow;
    logic [1:0]      oState;
    logic [NB-1:0]   oBreakHit;
    logic [XLEN-1:0] oPopPC, oPopData;
    logic [31:0]     oPopInstr;
    logic [5:0]      oPopRd;
    logic [$clog2(DEPTH):0] oCount;

    debug_trace_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_BREAK(NB)) dut (
        .clock(clock), .reset(reset), .iValid(iValid), .iPC(iPC),
        .iInstruction(iInstruction), .iRegWrite(iRegWrite), .iRd(iRd),
        .iWriteData(iWriteData), .iHaltReq(iHaltReq), .iRunReq(iRunReq),
        .iStepReq(iStepReq), .iBreakEn(iBreakEn), .iBreakAddr(iBreakAddr),
        .iPopReady(iPopReady), .oCoreEn(oCoreEn), .oState(oState),
        .oBreakHit(oBreakHit), .oPopValid(oPopValid), .oPopPC(oPopPC),
        .oPopInstr(oPopInstr), .oPopRd(oPopRd), .oPopData(oPopData),
        .oCount(oCount), .oOverflow(oOverflow)
    );

    always #5 clock = ~clock;

    // Reference model: a bounded FIFO of retired instructions plus run state.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    int          m_state;   // 0 run, 1 halted, 2 step
    bit          m_ovf;
    logic [NB-1:0] m_hit;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_state = 1;
        m_ovf   = 1'b0;
        m_hit   = '0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_pc, e_in, e_da;
        logic [5:0]  e_rd;
        e_pc = 0; e_in = 0; e_rd = 0; e_da = 0;
        if (m_q.size() != 0) begin
            e_pc = m_q[0].pc; e_in = m_q[0].instr; e_rd = m_q[0].rd;
`ifdef TRACE_WDATA_EN
            e_da = m_q[0].data;
`endif
        end
        chk({tag, ".state"},  64'(oState),    64'(m_state));
        chk({tag, ".coreen"}, 64'(oCoreEn),   64'(m_state != 1));
        chk({tag, ".count"},  64'(oCount),    64'(m_q.size()));
        chk({tag, ".valid"},  64'(oPopValid), 64'(m_q.size() != 0));
        chk({tag, ".ovf"},    64'(oOverflow), 64'(m_ovf));
        chk({tag, ".hit"},    64'(oBreakHit), 64'(m_hit));
        chk({tag, ".pc"},     64'(oPopPC),    64'(e_pc));
        chk({tag, ".instr"},  64'(oPopInstr), 64'(e_in));
        chk({tag, ".rd"},     64'(oPopRd),    64'(e_rd));
        chk({tag, ".data"},   64'(oPopData),  64'(e_da));
    endtask

    task automatic clr();
        iValid = 0; iRunReq = 0; iStepReq = 0; iPopReady = 0;
    endtask

    task automatic set_retire(input logic [31:0] pc);
        iValid       = 1;
        iPC          = pc;
        iInstruction = $urandom;
        iRegWrite    = 1'($urandom);
        iRd          = 5'($urandom);
        iWriteData   = $urandom;
    endtask

    // Advance one clock: update the model from the applied inputs, then compare.
    task automatic tick(input string tag);
        int ns;
        bit ret, popd;
        logic [NB-1:0] mt;
        ent_t e;
        ns  = m_state;
        ret = iValid && (m_state != 1);
        mt  = '0;
        for (int k = 0; k < NB; k++)
            if (ret && iBreakEn[k] && iPC == iBreakAddr[k*XLEN +: XLEN]) mt[k] = 1'b1;
        case (m_state)
            0: if (iHaltReq || mt != 0) ns = 1;
            1: if (iRunReq && !iHaltReq) ns = 0; else if (iStepReq) ns = 2;
            default: if (ret || iHaltReq) ns = 1;
        endcase
        popd = iPopReady && (m_q.size() != 0);
        if (popd) void'(m_q.pop_front());
        if (ret) begin
            e.pc = iPC; e.instr = iInstruction; e.rd = {iRegWrite, iRd}; e.data = iWriteData;
            m_q.push_back(e);
            if (m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
        end
        if (popd && !ret && m_q.size() == 0) m_ovf = 1'b0;
        m_hit = (iRunReq ? '0 : m_hit) | mt;
        @(posedge clock);
        #1;
        m_state = ns;
        check_all(tag);
        clr();
    endtask

    initial begin
        reset = 1; iHaltReq = 0; iBreakEn = '0; iBreakAddr = '0;
        iPC = 0; iInstruction = 0; iRegWrite = 0; iRd = 0; iWriteData = 0;
        clr();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset = 0;

        // Run, retire three, pop them back in order
        iRunReq = 1; tick("run");
        set_retire(32'h00); tick("ret0");
        set_retire(32'h04); tick("ret4");
        set_retire(32'h08); tick("ret8");
        chk("three.count", 64'(oCount), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("pop.order", 64'(oPopPC), 64'(i * 4));
            iPopReady = 1; tick("pop");
        end
        chk("drained.valid", 64'(oPopValid), 64'd0);

        // Breakpoint on 0x10
        iBreakEn = 2'b01; iBreakAddr[0 +: XLEN] = 32'h10; iBreakAddr[XLEN +: XLEN] = 32'hFFFF_FFF0;
        set_retire(32'h0C); tick("bp0c");
        set_retire(32'h10); tick("bp10");
        set_retire(32'h14); tick("bp14");
        chk("bp.state", 64'(oState), 64'd1);
        chk("bp.hit",   64'(oBreakHit), 64'd1);
        chk("bp.count", 64'(oCount), 64'd2);

        // Single step
        iStepReq = 1; tick("step.req");
        chk("step.coreen", 64'(oCoreEn), 64'd1);
        tick("step.idle");
        set_retire(32'h18); tick("step.ret");
        chk("step.back", 64'(oState), 64'd1);
        chk("step.count", 64'(oCount), 64'd3);
        set_retire(32'h1C); tick("halted.noret");
        for (int i = 0; i < 3; i++) begin iPopReady = 1; tick("step.drain"); end

        // Overflow: 18 retires, no pops
        iBreakEn = '0; iRunReq = 1; tick("run2");
        for (int i = 0; i < 18; i++) begin set_retire(32'h200 + 32'(4 * i)); tick("fill"); end
        chk("ovf.count", 64'(oCount), 64'd16);
        chk("ovf.flag",  64'(oOverflow), 64'd1);
        chk("ovf.head",  64'(oPopPC), 64'h208);

        // Drain (clears overflow), refill exactly, then push+pop while full
        for (int i = 0; i < 16; i++) begin iPopReady = 1; tick("drain"); end
        chk("drain.ovf", 64'(oOverflow), 64'd0);
        for (int i = 0; i < 16; i++) begin set_retire(32'h400 + 32'(4 * i)); tick("refill"); end
        for (int i = 0; i < 5; i++) begin
            set_retire(32'h500 + 32'(4 * i)); iPopReady = 1; tick("fullpp");
            chk("fullpp.count", 64'(oCount), 64'd16);
            chk("fullpp.ovf", 64'(oOverflow), 64'd0);
        end
        chk("fullpp.head", 64'(oPopPC), 64'h414);

        // Randomised run-control / trace traffic
        iBreakEn = 2'($urandom_range(1, 3));
        iBreakAddr[0 +: XLEN] = 32'h108; iBreakAddr[XLEN +: XLEN] = 32'h114;
        for (int i = 0; i < 400; i++) begin
            iHaltReq = ($urandom_range(0, 15) == 0);
            iRunReq  = ($urandom_range(0, 7) == 0);
            iStepReq = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0) set_retire(32'h100 + 32'(4 * $urandom_range(0, 7)));
            iPopReady = ($urandom_range(0, 2) == 0);
            tick("rand");
        end
        iHaltReq = 0;

        // Asynchronous reset mid-run with five entries held
        iBreakEn = '0;
        for (int i = 0; i < 20; i++) begin iPopReady = 1; tick("pre.drain"); end
        iRunReq = 1; tick("run3");
        for (int i = 0; i < 5; i++) begin set_retire(32'h600 + 32'(4 * i)); tick("pre.rst"); end
        chk("prerst.count", 64'(oCount), 64'd5);
        #2 reset = 1;
        #1;
        model_reset();
        check_all("async.rst");
        @(posedge clock); #1;
        check_all("rst.hold");
        reset = 0;
        tick("post.rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
